cordic_phase_gen: RTL and testbench

- Upstream driver for the CORDIC rotator. Generates a sample-rate clock-enable, a phase-accumulator (NCO) phase word, and the pre-scaled start vector (AMP, 0), so that the rotator output is cos/sin at unity amplitude.
- Accepts frequency-tuning-word updates through a load/ack handshake.
- Tracks the rotator's pipeline fill so downstream logic knows when rotator outputs are meaningful.

---
 rtl/cordic_pkg.sv | 20 ++
 rtl/cordic_phase_gen_tick.sv | 36 +++
 rtl/cordic_phase_gen.sv | 146 ++++++++++++++
 tb/tb_cordic_phase_gen.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC phase generator and the rotator it feeds.
package cordic_pkg;

  localparam int PW      = 12;
  localparam int IW      = 6;
  localparam int NSTAGES = 11;
  localparam int AMP     = 19;

  typedef logic [PW-1:0] phase_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } state_t;

  // Quarter turn in phase units; the rotator uses it for its pre-rotation.
  localparam phase_t PHASE_90 = phase_t'(1) << (PW - 2);

endpackage

// File: rtl/cordic_phase_gen_tick.sv
// Sample-rate divider: emits a one-clock enable every (div + 1) clocks while run is high.
module sample_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             enable
);

  logic [DIV_W-1:0] count_q;
  logic             enable_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values; reset is sampled on the clock edge, not asynchronously.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q  <= '0;
      enable_q <= 1'b0;
    end else if (!run) begin
      count_q  <= '0;
      enable_q <= 1'b0;
    end else if (count_q >= div) begin
      // >= rather than == so a divider lowered below the count wraps at once.
      count_q  <= '0;
      enable_q <= 1'b1;
    end else begin
      count_q  <= count_q + 1'b1;
      enable_q <= 1'b0;
    end
  end

  assign enable = enable_q;

endmodule

// File: rtl/cordic_phase_gen.sv
// NCO front end for the CORDIC rotator: sample tick, phase word, FTW handshake and pipeline-fill tracking.
module cordic_phase_gen #(
  parameter int PW        = cordic_pkg::PW,
  parameter int IW        = cordic_pkg::IW,
  parameter int NSTAGES   = cordic_pkg::NSTAGES,
  parameter int DIV_W     = 16,
  parameter int AMP       = cordic_pkg::AMP,
  parameter int WRAP_SYNC = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_run,
  input  logic [DIV_W-1:0]     i_div,
  input  logic [PW-1:0]        i_ftw,
  input  logic                 i_ftw_load,
  output logic                 o_ftw_ack,
  output logic                 o_enable,
  output logic [PW-1:0]        o_phase,
  output logic signed [IW-1:0] o_xval,
  output logic signed [IW-1:0] o_yval,
  output logic                 o_valid,
  output logic                 o_out_stb,
  output logic                 o_wrap
);

  import cordic_pkg::*;

  localparam int FW = $clog2(NSTAGES + 1);

  state_t        state_q;
  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;
  logic [PW-1:0] ftw_act_q;
  logic [PW-1:0] ftw_pend_q;
  logic          pend_q;
  logic          carry_d;
  logic          activate_d;
  logic          ack_q;
  logic          valid_q;
  logic          out_stb_q;
  logic          wrap_q;
  logic [FW-1:0] fill_q;
  logic          tick_run;
  logic          enable;

  // Dropping i_run stops the divider on the same edge the FSM leaves FILL/STREAM.
  assign tick_run = (state_q != IDLE) && i_run;

  sample_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (tick_run),
    .div     (i_div),
    .enable  (enable)
  );

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    {carry_d, phase_d} = {1'b0, phase_q} + {1'b0, ftw_act_q};
    activate_d         = 1'b0;
    if (pend_q) begin
      if (state_q == IDLE) begin
        // Accumulator is parked, so there is no phase continuity to protect.
        activate_d = 1'b1;
      end else if (enable) begin
        // A zero FTW never carries, so it would otherwise block the swap forever.
        activate_d = (WRAP_SYNC == 0) || carry_d || (ftw_act_q == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      ftw_act_q  <= '0;
      ftw_pend_q <= '0;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      out_stb_q  <= 1'b0;
      wrap_q     <= 1'b0;
      fill_q     <= '0;
    end else begin
      ack_q     <= activate_d;
      wrap_q    <= enable && carry_d;
      out_stb_q <= enable && valid_q;

      if (enable) begin
        phase_q <= phase_d;
      end

      if (activate_d) begin
        ftw_act_q <= ftw_pend_q;
        pend_q    <= 1'b0;
      end
      // A load coinciding with activation re-arms the pending register.
      if (i_ftw_load) begin
        ftw_pend_q <= i_ftw;
        pend_q     <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (i_run) begin
            state_q <= FILL;
            fill_q  <= '0;
          end
        end
        FILL: begin
          if (!i_run) begin
            state_q <= IDLE;
          end else if (enable) begin
            fill_q <= fill_q + 1'b1;
            if (fill_q == FW'(NSTAGES - 1)) begin
              state_q <= STREAM;
              valid_q <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (!i_run) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_ftw_ack = ack_q;
  assign o_enable  = enable;
  assign o_phase   = phase_q;
  assign o_valid   = valid_q;
  assign o_out_stb = out_stb_q;
  assign o_wrap    = wrap_q;
  assign o_xval    = IW'(AMP);
  assign o_yval    = '0;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed bench for cordic_phase_gen: divider, phase stepping, FTW handshake, fill tracking and reset.
module tb_cordic_phase_gen;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               i_run;
  logic [15:0]        i_div;
  logic [11:0]        i_ftw;
  logic               i_ftw_load;
  logic               o_ftw_ack;
  logic               o_enable;
  logic [11:0]        o_phase;
  logic signed [5:0]  o_xval;
  logic signed [5:0]  o_yval;
  logic               o_valid;
  logic               o_out_stb;
  logic               o_wrap;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cordic_phase_gen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_run      (i_run),
    .i_div      (i_div),
    .i_ftw      (i_ftw),
    .i_ftw_load (i_ftw_load),
    .o_ftw_ack  (o_ftw_ack),
    .o_enable   (o_enable),
    .o_phase    (o_phase),
    .o_xval     (o_xval),
    .o_yval     (o_yval),
    .o_valid    (o_valid),
    .o_out_stb  (o_out_stb),
    .o_wrap     (o_wrap)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick(input int budget, output int waited, output bit ok);
    waited = 0;
    do begin
      cyc(1);
      waited++;
    end while (o_enable !== 1'b1 && waited < budget);
    ok = (o_enable === 1'b1);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    i_run      = 1'b0;
    i_ftw_load = 1'b0;
    cyc(2);
    reset_n = 1'b1;
  endtask

  task automatic load_ftw(input logic [11:0] v);
    i_ftw      = v;
    i_ftw_load = 1'b1;
    cyc(1);
    i_ftw_load = 1'b0;
  endtask

  task automatic test_reset();
    logic [16:0] flat;
    reset_n    = 1'b0;
    i_run      = 1'b0;
    i_div      = '0;
    i_ftw      = '0;
    i_ftw_load = 1'b0;
    cyc(3);
    flat = {o_enable, o_phase, o_ftw_ack, o_valid, o_out_stb, o_wrap};
    n_cmp++;
    if (flat !== 17'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0", flat);
    end
    n_cmp++;
    if (o_xval !== 6'sd19) begin
      n_err++;
      $display("FAIL reset_xval: got %0d expected 19", o_xval);
    end
    n_cmp++;
    if (o_yval !== 6'sd0) begin
      n_err++;
      $display("FAIL reset_yval: got %0d expected 0", o_yval);
    end
    reset_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_basic_fill();
    int w;
    bit ok;
    logic [11:0] exp_ph;
    do_reset();
    i_div = 16'd3;
    load_ftw(12'h100);
    cyc(1);
    n_cmp++;
    if (o_ftw_ack !== 1'b1) begin
      n_err++;
      $display("FAIL idle_load_ack: got %b expected 1", o_ftw_ack);
    end
    i_run = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      wait_tick(16, w, ok);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL basic_tick%0d: no tick within 16 clocks", k);
      end
      if (k > 1) begin
        n_cmp++;
        if (w != ((k == 12) ? 3 : 4)) begin
          n_err++;
          $display("FAIL basic_gap%0d: got %0d clocks expected %0d", k, w, (k == 12) ? 3 : 4);
        end
      end
      exp_ph = 12'((k - 1) * 256);
      n_cmp++;
      if (o_phase !== exp_ph) begin
        n_err++;
        $display("FAIL basic_phase%0d: got %h expected %h", k, o_phase, exp_ph);
      end
      if (k <= 11) begin
        n_cmp++;
        if (o_valid !== 1'b0) begin
          n_err++;
          $display("FAIL basic_valid_early%0d: got %b expected 0", k, o_valid);
        end
      end
      if (k == 11) begin
        cyc(1);
        n_cmp++;
        if (o_valid !== 1'b1) begin
          n_err++;
          $display("FAIL basic_valid_rise: got %b expected 1", o_valid);
        end
        n_cmp++;
        if (o_out_stb !== 1'b0) begin
          n_err++;
          $display("FAIL basic_stb_after_fill: got %b expected 0", o_out_stb);
        end
      end
    end
    n_cmp++;
    if (o_out_stb !== 1'b0) begin
      n_err++;
      $display("FAIL basic_stb_on_tick: got %b expected 0", o_out_stb);
    end
    cyc(1);
    n_cmp++;
    if (o_out_stb !== 1'b1) begin
      n_err++;
      $display("FAIL basic_stb_first: got %b expected 1", o_out_stb);
    end
    cyc(1);
    n_cmp++;
    if (o_out_stb !== 1'b0) begin
      n_err++;
      $display("FAIL basic_stb_single: got %b expected 0", o_out_stb);
    end
    n_cmp++;
    if (o_xval !== 6'sd19 || o_yval !== 6'sd0) begin
      n_err++;
      $display("FAIL basic_start_vector: got (%0d,%0d) expected (19,0)", o_xval, o_yval);
    end
    i_run = 1'b0;
    cyc(2);
  endtask

  task automatic test_div0_wrap();
    int w;
    bit ok;
    logic [11:0] exp_ph;
    do_reset();
    i_div = 16'd0;
    load_ftw(12'h400);
    cyc(1);
    i_run = 1'b1;
    wait_tick(8, w, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL div0_first_tick: no tick within 8 clocks");
    end
    for (int k = 0; k <= 4; k++) begin
      exp_ph = 12'((k * 1024) % 4096);
      n_cmp++;
      if (o_enable !== 1'b1 || o_phase !== exp_ph || o_wrap !== (k == 4)) begin
        n_err++;
        $display("FAIL div0_step%0d: got en=%b ph=%h wrap=%b expected en=1 ph=%h wrap=%b",
                 k, o_enable, o_phase, o_wrap, exp_ph, (k == 4));
      end
      cyc(1);
    end
    n_cmp++;
    if (o_wrap !== 1'b0) begin
      n_err++;
      $display("FAIL div0_wrap_single: got %b expected 0", o_wrap);
    end
    i_run = 1'b0;
    cyc(2);
  endtask

  task automatic test_wrap_sync();
    int w;
    bit ok;
    logic [11:0] exp_ph [0:8];
    exp_ph = '{12'h000, 12'h300, 12'h600, 12'h900, 12'hC00, 12'hF00, 12'h200, 12'h280, 12'h300};
    do_reset();
    i_div = 16'd0;
    load_ftw(12'h300);
    cyc(1);
    i_run = 1'b1;
    wait_tick(8, w, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL wsync_first_tick: no tick within 8 clocks");
    end
    for (int i = 0; i <= 8; i++) begin
      n_cmp++;
      if (o_phase !== exp_ph[i] || o_ftw_ack !== (i == 6) || o_wrap !== (i == 6)) begin
        n_err++;
        $display("FAIL wsync_step%0d: got ph=%h ack=%b wrap=%b expected ph=%h ack=%b wrap=%b",
                 i, o_phase, o_ftw_ack, o_wrap, exp_ph[i], (i == 6), (i == 6));
      end
      if (i == 0) begin
        i_ftw      = 12'h080;
        i_ftw_load = 1'b1;
      end
      cyc(1);
      i_ftw_load = 1'b0;
    end
    i_run = 1'b0;
    cyc(2);
  endtask

  task automatic test_back_to_back_load();
    int w;
    bit ok;
    int acks;
    logic [11:0] exp_ph [0:8];
    exp_ph = '{12'h000, 12'h300, 12'h600, 12'h900, 12'hC00, 12'hF00, 12'h200, 12'h220, 12'h240};
    acks = 0;
    do_reset();
    i_div = 16'd0;
    load_ftw(12'h300);
    cyc(1);
    i_run = 1'b1;
    wait_tick(8, w, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL b2b_first_tick: no tick within 8 clocks");
    end
    for (int i = 0; i <= 8; i++) begin
      if (o_ftw_ack === 1'b1) acks++;
      n_cmp++;
      if (o_phase !== exp_ph[i]) begin
        n_err++;
        $display("FAIL b2b_phase%0d: got %h expected %h", i, o_phase, exp_ph[i]);
      end
      i_ftw_load = (i <= 1);
      i_ftw      = (i == 0) ? 12'h010 : 12'h020;
      cyc(1);
      i_ftw_load = 1'b0;
    end
    n_cmp++;
    if (acks != 1) begin
      n_err++;
      $display("FAIL b2b_ack_count: got %0d expected 1", acks);
    end
    i_run = 1'b0;
    cyc(2);
  endtask

  task automatic test_run_drop();
    int w;
    bit ok;
    int ticks;
    bit seen_valid;
    logic [11:0] first_ph;
    do_reset();
    i_div = 16'd0;
    load_ftw(12'h100);
    cyc(1);
    i_run = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      wait_tick(8, w, ok);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL drop_tick%0d: no tick within 8 clocks", k);
      end
    end
    i_run = 1'b0;
    cyc(1);
    n_cmp++;
    if (o_enable !== 1'b0 || o_phase !== 12'h500 || o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drop_stop: got en=%b ph=%h valid=%b expected en=0 ph=500 valid=0",
               o_enable, o_phase, o_valid);
    end
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_enable === 1'b1) ticks++;
      cyc(1);
    end
    n_cmp++;
    if (ticks != 0 || o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drop_idle: got ticks=%0d valid=%b expected ticks=0 valid=0", ticks, o_valid);
    end
    i_run      = 1'b1;
    ticks      = 0;
    seen_valid = 1'b0;
    first_ph   = 'x;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (o_valid === 1'b1) begin
        seen_valid = 1'b1;
        break;
      end
      if (o_enable === 1'b1) begin
        if (ticks == 0) first_ph = o_phase;
        ticks++;
      end
    end
    n_cmp++;
    if (!seen_valid || ticks != 11) begin
      n_err++;
      $display("FAIL refill_ticks: got valid=%b after %0d ticks expected valid=1 after 11",
               seen_valid, ticks);
    end
    n_cmp++;
    if (first_ph !== 12'h500) begin
      n_err++;
      $display("FAIL refill_phase_kept: got %h expected 500", first_ph);
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [16:0] flat;
    int acks;
    n_cmp++;
    if (o_valid !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre_valid: got %b expected 1", o_valid);
    end
    load_ftw(12'h7FF);
    reset_n = 1'b0;
    i_run   = 1'b0;
    cyc(1);
    flat = {o_enable, o_phase, o_ftw_ack, o_valid, o_out_stb, o_wrap};
    n_cmp++;
    if (flat !== 17'd0 || o_xval !== 6'sd19 || o_yval !== 6'sd0) begin
      n_err++;
      $display("FAIL midrst_outputs: got %h x=%0d y=%0d expected 0 x=19 y=0", flat, o_xval, o_yval);
    end
    reset_n = 1'b1;
    acks    = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (o_ftw_ack === 1'b1) acks++;
    end
    n_cmp++;
    if (acks != 0 || o_phase !== 12'h000) begin
      n_err++;
      $display("FAIL midrst_no_ack: got acks=%0d ph=%h expected acks=0 ph=000", acks, o_phase);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_div0_wrap();
    test_wrap_sync();
    test_back_to_back_load();
    test_run_drop();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1);
  end

endmodule
